// File: rtl/pio_mailbox.sv
// Register mailbox between the HPS lightweight bridge and a fabric engine:
// shared CTRL word plus collision, done-interrupt and busy/done counters.
module pio_mailbox #(
  parameter int unsigned DATA_W     = 32,
  parameter bit          SAT_CYCLES = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              irq,
  output logic [DATA_W-1:0] ctrl_out,
  input  logic [DATA_W-1:0] fab_writedata,
  input  logic              fab_write
);

  typedef enum logic [2:0] {
    ADDR_CTRL     = 3'd0,
    ADDR_STATUS   = 3'd1,
    ADDR_IRQ_EN   = 3'd2,
    ADDR_CYCLES   = 3'd3,
    ADDR_DONE_CNT = 3'd4,
    ADDR_SCRATCH  = 3'd5
  } reg_addr_e;

  logic [DATA_W-1:0] ctrl_q;
  logic [DATA_W-1:0] cycles_q;
  logic [DATA_W-1:0] done_cnt_q;
  logic [DATA_W-1:0] scratch_q;
  logic [DATA_W-1:0] readdata_q;
  logic              collide_q;
  logic              done_pend_q;
  logic              irq_en_q;
  logic              busy_q;
  logic              irq_q;

  logic              hps_ctrl_wr;
  logic              status_wr;
  logic              busy_rise;
  logic              busy_fall;
  logic [DATA_W-1:0] rd_mux;

  always_comb begin
    hps_ctrl_wr = avs_write && (avs_address == ADDR_CTRL);
    status_wr   = avs_write && (avs_address == ADDR_STATUS);
    busy_rise   = ctrl_q[1] && !busy_q;
    busy_fall   = !ctrl_q[1] && busy_q;
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_CTRL:     rd_mux = ctrl_q;
      ADDR_STATUS:   rd_mux = {{(DATA_W-2){1'b0}}, done_pend_q, collide_q};
      ADDR_IRQ_EN:   rd_mux = {{(DATA_W-1){1'b0}}, irq_en_q};
      ADDR_CYCLES:   rd_mux = cycles_q;
      ADDR_DONE_CNT: rd_mux = done_cnt_q;
      ADDR_SCRATCH:  rd_mux = scratch_q;
      default:       rd_mux = '0;
    endcase
  end

  // Fabric write has priority on CTRL; a simultaneous HPS write is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
      busy_q <= 1'b0;
    end else begin
      if (fab_write)        ctrl_q <= fab_writedata;
      else if (hps_ctrl_wr) ctrl_q <= avs_writedata;
      busy_q <= ctrl_q[1];
    end
  end

  // Sticky status bits: a set event in the same cycle as W1C keeps the bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collide_q   <= 1'b0;
      done_pend_q <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      collide_q   <= (fab_write && hps_ctrl_wr) ||
                     (collide_q && !(status_wr && avs_writedata[0]));
      done_pend_q <= busy_fall ||
                     (done_pend_q && !(status_wr && avs_writedata[1]));
      if (avs_write && (avs_address == ADDR_IRQ_EN)) irq_en_q <= avs_writedata[0];
      irq_q <= done_pend_q && irq_en_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_q   <= '0;
      done_cnt_q <= '0;
    end else begin
      if (busy_rise) begin
        cycles_q <= '0;
      end else if (ctrl_q[1]) begin
        if (!(SAT_CYCLES && (cycles_q == '1))) cycles_q <= cycles_q + 1'b1;
      end
      if (busy_fall) done_cnt_q <= done_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scratch_q  <= '0;
      readdata_q <= '0;
    end else begin
      if (avs_write && (avs_address == ADDR_SCRATCH)) scratch_q <= avs_writedata;
      if (avs_read) readdata_q <= rd_mux;
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;
  assign ctrl_out     = ctrl_q;

endmodule

// File: doc/pio_mailbox.md
# pio_mailbox

- Register-mailbox responder between the HPS lightweight bridge (Avalon-MM slave side) and fabric compute state machines (conduit side).
- The HPS sets a command word; the fabric engine reads it and writes back status, e.g. start bit → busy → done.
- The block adds collision detection, a done interrupt, a busy-cycle counter and a completion counter, so software can poll or take an interrupt instead of spinning on a bare PIO.

## Interface
- DATA_W, 32, width of every register and data path (fixed 32 in this revision).
- SAT_CYCLES, 1, 1 = cycle counter saturates at all-ones; 0 = wraps.

Ports:
- clk  in  1  single clock for both sides.
- reset  in  1  asynchronous, active-high; all state cleared.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  HPS write data.
- avs_readdata  out  32  read data, fixed latency 1.
- irq  out  1  done interrupt, level.
- ctrl_out  out  32  current CTRL register, to the fabric.
- fab_writedata  in  32  fabric write data for CTRL.
- fab_write  in  1  fabric write strobe for CTRL.

## Operation
Register map (word address):
- 0 CTRL: RW from HPS and fabric. Bit0 = start request, bit1 = busy; other bits are free-form.
- 1 STATUS:
  - Bit0 COLLIDE (sticky), bit1 DONE_PEND (sticky), bits 31:2 read 0.
  - Write-1-to-clear.
- 2 IRQ_EN: bit0 enables irq; other bits read 0.
- 3 CYCLES: RO count of cycles during which CTRL[1]=1.
- 4 DONE_CNT: RO count of CTRL[1] 1→0 transitions; wraps at 2^32.
- 5 SCRATCH: RW, no side effects.
- 6, 7: read 0; writes ignored.

CTRL update:
- fab_write only: CTRL ← fab_writedata.
- HPS write to addr 0 only: CTRL ← avs_writedata.
- Both in the same cycle: fabric wins; the HPS data is dropped and COLLIDE is set.
- Neither: CTRL holds.

Events, derived from the registered CTRL[1] versus its value one cycle earlier (busy_q):
- Rising edge of CTRL[1]:
  - CYCLES ← 0 in the edge cycle.
  - CYCLES then increments every cycle while CTRL[1]=1.
  - SAT_CYCLES=1: saturate at 0xFFFFFFFF.
- Falling edge of CTRL[1]:
  - DONE_PEND ← 1.
  - DONE_CNT ← DONE_CNT+1.
  - CYCLES frozen until the next rising edge.

Sticky-bit priority:
- Set and W1C in the same cycle: set wins (bit stays 1).
- W1C with data bit = 0 leaves that bit unchanged.

Other rules:
- irq = DONE_PEND & IRQ_EN[0], registered.
- avs_read and avs_write in the same cycle: both are performed; read returns the pre-write value.
- Reads have no side effects.

## Timing
- Reset values: all registers 0, avs_readdata 0, irq 0, ctrl_out 0, busy_q 0.
- Reset asserted mid-operation clears everything immediately. No falling-edge event is generated by that clear.
- ctrl_out = CTRL register: a write in cycle N is visible on ctrl_out in cycle N+1.
- avs_readdata:
  - Read in cycle N returns data in cycle N+1.
  - It holds its value until the next read.
  - No waitrequest; back-to-back reads every cycle are supported.
- Edge detection: CTRL[1] changes in cycle N+1 (after a write in N).
  - Rising edge: CYCLES reads 0 in N+2, 1 in N+3, …
  - Falling edge: DONE_PEND and DONE_CNT update in N+2; irq asserts in N+3.
- CYCLES after a busy window of B cycles (CTRL[1]=1 for B cycles) reads B−1.
- Collision: COLLIDE is readable set the cycle after the colliding write.

## Test plan
- Reset:
  - Stimulus: assert reset asynchronously mid-cycle.
  - Required: ctrl_out, irq and avs_readdata go to 0 without a clock edge; all reads return 0 after release.
- Handshake:
  - Stimulus: HPS writes CTRL=0x1; fabric writes 0x2 two cycles later, then 0x0 ten cycles after that.
  - Required: ctrl_out sequence 0x1 → 0x2 → 0x0; CYCLES=9; DONE_CNT=1; STATUS=0x2.
- Interrupt:
  - Stimulus: IRQ_EN=1, complete one busy pulse.
  - Required: irq=1 exactly 2 cycles after CTRL[1] falls.
  - Stimulus: W1C STATUS=0x2.
  - Required: irq=0 two cycles after that write.
- Collision:
  - Stimulus: HPS writes CTRL=0xAAAA5555 and fabric writes 0x12345678 in the same cycle.
  - Required: ctrl_out=0x12345678; STATUS bit0=1.
  - Stimulus: W1C 0x1.
  - Required: STATUS bit0 clears.
- Set beats clear:
  - Stimulus: W1C DONE_PEND in the same cycle as a CTRL[1] falling edge.
  - Required: DONE_PEND stays 1.
- Counter limits:
  - Stimulus: force CYCLES to 0xFFFFFFFE with CTRL[1] held high.
  - Required: SAT_CYCLES=1 holds 0xFFFFFFFF; SAT_CYCLES=0 wraps to 0.
  - Stimulus: DONE_CNT at 0xFFFFFFFF plus one more done.
  - Required: DONE_CNT wraps to 0.
